// File: rtl/div.sv
// rtl/div.sv - 16/8 unsigned restoring divider, one quotient bit per cycle
module div (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] a_bi,
    input  logic [7:0]  b_bi,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] q_bo,
    output logic [7:0]  r_bo,
    output logic        dbz_o
);

    typedef enum logic {IDLE, WORK} state_t;

    state_t      state, state_nxt;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] quo;
    logic [8:0]  prem;
    logic [3:0]  cnt;
    logic [9:0]  trial;
    logic        ge;
    logic [8:0]  diff;
    logic        last;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i) state_nxt = WORK;
            WORK: if (last)    state_nxt = IDLE;
            default:           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state == WORK);
    end

    // Restoring step: the partial remainder stays below the divisor, so the
    // shifted trial never exceeds 9 significant bits for a non-zero divisor.
    always_comb begin
        trial = {prem, dvd[15]};
        ge    = (trial >= {2'b00, dvs});
        diff  = ge ? (trial[8:0] - {1'b0, dvs}) : trial[8:0];
        last  = (cnt == 4'd15);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dvd    <= '0;
            dvs    <= '0;
            quo    <= '0;
            prem   <= '0;
            cnt    <= '0;
            done_o <= 1'b0;
            q_bo   <= '0;
            r_bo   <= '0;
            dbz_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        dvd  <= a_bi;
                        dvs  <= b_bi;
                        quo  <= '0;
                        prem <= '0;
                        cnt  <= '0;
                    end
                end
                WORK: begin
                    dvd  <= {dvd[14:0], 1'b0};
                    quo  <= {quo[14:0], ge};
                    prem <= diff;
                    cnt  <= cnt + 4'd1;
                    if (last) begin
                        done_o <= 1'b1;
                        if (dvs == 8'd0) begin
                            q_bo  <= 16'hFFFF;
                            r_bo  <= 8'h00;
                            dbz_o <= 1'b1;
                        end else begin
                            q_bo  <= {quo[14:0], ge};
                            r_bo  <= diff[7:0];
                            dbz_o <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
